stream_downsize: RTL and testbench



---
 rtl/stream_pkg.sv | 22 ++
 rtl/stream_lane_mux.sv | 15 +
 rtl/stream_downsize.sv | 93 +++++++++
 tb/tb_stream_downsize.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared types and helpers for the stream width converters
package stream_pkg;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_e;

    function automatic int lane_idx_w(input int ratio);
        return $clog2(ratio);
    endfunction

    function automatic int keep_count(input logic [31:0] keep);
        int count;
        count = 0;
        for (int i = 0; i < 32; i++) begin
            count += int'(keep[i]);
        end
        return count;
    endfunction

endpackage

// File: rtl/stream_lane_mux.sv
// rtl/stream_lane_mux.sv - selects one narrow lane out of a wide word
module stream_lane_mux
    import stream_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int RATIO = 2
) (
    input  logic [WIDTH*RATIO-1:0]       wide,
    input  logic [lane_idx_w(RATIO)-1:0] sel,
    output logic [WIDTH-1:0]             lane
);

    assign lane = wide[sel*WIDTH +: WIDTH];

endmodule

// File: rtl/stream_downsize.sv
// rtl/stream_downsize.sv - wide-to-narrow stream converter, lane 0 first
module stream_downsize
    import stream_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int RATIO = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic [WIDTH*RATIO-1:0] s_data_i,
    input  logic [RATIO-1:0]       s_keep_i,
    input  logic                   s_last_i,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [WIDTH-1:0]       m_data_o,
    output logic                   m_last_o
);

    localparam int IW = lane_idx_w(RATIO);

    state_e                 state;
    logic [WIDTH*RATIO-1:0] hold_data;
    logic [IW-1:0]          hold_last_idx;
    logic                   hold_last;
    logic [IW-1:0]          idx;

    int   n_in;
    logic final_lane;
    logic s_accept;
    logic m_accept;
    logic load;

    always_comb begin
        n_in = keep_count(32'(s_keep_i));
    end

    // The held lane count is stored as n-1 so it fits the lane index width.
    assign final_lane = (state == SEND) && (idx == hold_last_idx);
    assign s_ready_o  = !rst_i && ((state == EMPTY) || (final_lane && m_ready_i));
    assign s_accept   = s_valid_i && s_ready_o;
    assign m_valid_o  = (state == SEND);
    assign m_accept   = m_valid_o && m_ready_i;
    assign load       = s_accept && (n_in != 0);
    assign m_last_o   = final_lane && hold_last;

    stream_lane_mux #(
        .WIDTH (WIDTH),
        .RATIO (RATIO)
    ) u_lane_mux (
        .wide (hold_data),
        .sel  (idx),
        .lane (m_data_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= EMPTY;
            idx           <= '0;
            hold_data     <= '0;
            hold_last_idx <= '0;
            hold_last     <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (load) begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (m_accept && !final_lane) begin
                        idx <= idx + 1'b1;
                    end else if (m_accept && !load) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
            if (load) begin
                hold_data     <= s_data_i;
                hold_last_idx <= IW'(n_in - 1);
                hold_last     <= s_last_i;
                idx           <= '0;
            end
        end
    end

    // Keep must be a run of ones starting at lane 0.
    a_keep_contiguous: assert property (@(posedge clk_i) disable iff (rst_i)
        s_accept |-> ((s_keep_i & (s_keep_i + RATIO'(1))) == '0));

endmodule

// File: tb/tb_stream_downsize.sv
// tb/tb_stream_downsize.sv - directed self-checking bench for stream_downsize
module tb_stream_downsize;

    logic       clk_i;
    logic       rst_i;
    logic       s_valid_i;
    logic       s_ready_o;
    logic [7:0] s_data_i;
    logic [1:0] s_keep_i;
    logic       s_last_i;
    logic       m_valid_o;
    logic       m_ready_i;
    logic [3:0] m_data_o;
    logic       m_last_o;

    int checks   = 0;
    int failures = 0;

    stream_downsize #(
        .WIDTH (4),
        .RATIO (2)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .s_data_i  (s_data_i),
        .s_keep_i  (s_keep_i),
        .s_last_i  (s_last_i),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_data_o  (m_data_o),
        .m_last_o  (m_last_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] k, input logic l);
        s_valid_i = v;
        s_data_i  = d;
        s_keep_i  = k;
        s_last_i  = l;
    endtask

    initial begin
        rst_i     = 1'b0;
        m_ready_i = 1'b0;
        drive(1'b0, 8'h00, 2'b00, 1'b0);

        // 1. asynchronous reset before any clock edge, then release
        #1 rst_i = 1'b1;
        #1;
        chk("rst_m_valid", m_valid_o, 1'b0);
        chk("rst_s_ready", s_ready_o, 1'b0);
        chk("rst_m_data",  m_data_o,  4'h0);
        chk("rst_m_last",  m_last_o,  1'b0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rel_s_ready", s_ready_o, 1'b1);
        chk("rel_m_valid", m_valid_o, 1'b0);

        // 2. single full beat
        m_ready_i = 1'b1;
        drive(1'b1, 8'hA5, 2'b11, 1'b1);
        #1 chk("t2_s_ready_empty", s_ready_o, 1'b1);
        @(negedge clk_i);
        s_valid_i = 1'b0;
        #1;
        chk("t2_l0_valid", m_valid_o, 1'b1);
        chk("t2_l0_data",  m_data_o,  4'h5);
        chk("t2_l0_last",  m_last_o,  1'b0);
        chk("t2_l0_ready", s_ready_o, 1'b0);
        @(negedge clk_i); #1;
        chk("t2_l1_data",  m_data_o,  4'hA);
        chk("t2_l1_last",  m_last_o,  1'b1);
        chk("t2_l1_ready", s_ready_o, 1'b1);
        @(negedge clk_i); #1;
        chk("t2_drop_valid", m_valid_o, 1'b0);

        // 3. back-to-back beats with no bubble
        drive(1'b1, 8'h21, 2'b11, 1'b0);
        @(negedge clk_i);
        drive(1'b1, 8'h43, 2'b11, 1'b1);
        #1;
        chk("t3_c1_data",  m_data_o,  4'h1);
        chk("t3_c1_last",  m_last_o,  1'b0);
        chk("t3_c1_ready", s_ready_o, 1'b0);
        @(negedge clk_i); #1;
        chk("t3_c2_data",  m_data_o,  4'h2);
        chk("t3_c2_last",  m_last_o,  1'b0);
        chk("t3_c2_ready", s_ready_o, 1'b1);
        @(negedge clk_i);
        s_valid_i = 1'b0;
        #1;
        chk("t3_c3_valid", m_valid_o, 1'b1);
        chk("t3_c3_data",  m_data_o,  4'h3);
        chk("t3_c3_last",  m_last_o,  1'b0);
        @(negedge clk_i); #1;
        chk("t3_c4_data",  m_data_o,  4'h4);
        chk("t3_c4_last",  m_last_o,  1'b1);
        chk("t3_c4_ready", s_ready_o, 1'b1);
        @(negedge clk_i); #1;
        chk("t3_end_valid", m_valid_o, 1'b0);

        // 4. backpressure holds lane 0 stable
        m_ready_i = 1'b0;
        drive(1'b1, 8'hA5, 2'b11, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            s_valid_i = 1'b0;
            #1;
            chk("t4_bp_valid", m_valid_o, 1'b1);
            chk("t4_bp_data",  m_data_o,  4'h5);
            chk("t4_bp_ready", s_ready_o, 1'b0);
        end
        @(negedge clk_i);
        m_ready_i = 1'b1;
        #1 chk("t4_rel_data", m_data_o, 4'h5);
        @(negedge clk_i); #1;
        chk("t4_l1_data", m_data_o, 4'hA);
        chk("t4_l1_last", m_last_o, 1'b1);
        @(negedge clk_i); #1;
        chk("t4_end_valid", m_valid_o, 1'b0);

        // 5. partial keep: one lane only
        drive(1'b1, 8'hF7, 2'b01, 1'b1);
        @(negedge clk_i);
        s_valid_i = 1'b0;
        #1;
        chk("t5_valid", m_valid_o, 1'b1);
        chk("t5_data",  m_data_o,  4'h7);
        chk("t5_last",  m_last_o,  1'b1);
        chk("t5_ready", s_ready_o, 1'b1);
        @(negedge clk_i); #1;
        chk("t5_end_valid", m_valid_o, 1'b0);

        // 6a. zero keep is swallowed
        drive(1'b1, 8'h99, 2'b00, 1'b1);
        #1 chk("t6_zk_ready", s_ready_o, 1'b1);
        @(negedge clk_i);
        s_valid_i = 1'b0;
        #1;
        chk("t6_zk_valid", m_valid_o, 1'b0);
        chk("t6_zk_empty_ready", s_ready_o, 1'b1);

        // 6b. reset after lane 0 transfers loses lane 1
        drive(1'b1, 8'hA5, 2'b11, 1'b1);
        @(negedge clk_i);
        s_valid_i = 1'b0;
        #1 chk("t6_l0_data", m_data_o, 4'h5);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        #1;
        chk("t6_rst_valid", m_valid_o, 1'b0);
        chk("t6_rst_data",  m_data_o,  4'h0);
        chk("t6_rst_last",  m_last_o,  1'b0);
        chk("t6_rst_ready", s_ready_o, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("t6_rel_ready", s_ready_o, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i); #1;
            chk("t6_quiet_valid", m_valid_o, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
